// File: rtl/risc_toy_pkg.sv
// Shared definitions for the risc_toy front end: datapath widths, reset
// vector, queue entry layout and the opcode map used by decode.
package risc_toy_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 30;
    localparam int PC_W    = 32;

    localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [6:0] {
        OPC_LOAD     = 7'b0000011,
        OPC_MISC_MEM = 7'b0001111,
        OPC_OP_IMM   = 7'b0010011,
        OPC_AUIPC    = 7'b0010111,
        OPC_STORE    = 7'b0100011,
        OPC_OP       = 7'b0110011,
        OPC_LUI      = 7'b0110111,
        OPC_BRANCH   = 7'b1100011,
        OPC_JALR     = 7'b1100111,
        OPC_JAL      = 7'b1101111,
        OPC_SYSTEM   = 7'b1110011
    } opcode_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } ifq_entry_t;

    localparam int ENTRY_W = $bits(ifq_entry_t);

    // Byte addresses are forced onto a word boundary by masking the low bits.
    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
        return pc & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/risc_toy_ifq.sv
// Instruction queue: a small circular FIFO with a synchronous flush that
// outranks push and pop, and a zero head when empty.
module risc_toy_ifq
    import risc_toy_pkg::*;
#(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = ENTRY_W,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & ~flush & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/risc_toy_fetch.sv
// Fetch stage: credit-gated instruction requests, one outstanding response
// tracked by PC, and a queue feeding decode; redirects flush everything.
module risc_toy_fetch
    import risc_toy_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int              DEPTH    = 2
) (
    input  logic               CLK,
    input  logic               RSTN,
    output logic               IREQ,
    output logic [ADDR_W-1:0]  IADDR,
    input  logic [INSTR_W-1:0] INSTR,
    input  logic               REDIR_VALID,
    input  logic [PC_W-1:0]    REDIR_PC,
    output logic               ID_VALID,
    input  logic               ID_READY,
    output logic [INSTR_W-1:0] ID_INSTR,
    output logic [PC_W-1:0]    ID_PC
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [PC_W-1:0] fpc;
    logic            inflight;
    logic [PC_W-1:0] inflight_pc;

    logic            push;
    logic            pop;
    logic            q_full;
    logic            q_empty;
    logic [CW-1:0]   q_count;
    logic [CW:0]     occupancy;
    ifq_entry_t      q_din;
    ifq_entry_t      q_dout;

    assign ID_VALID = ~q_empty & ~REDIR_VALID;
    assign pop      = ID_VALID & ID_READY;

    // Issue only when the entry being freed this cycle plus queued and
    // outstanding work still leaves room, so a response always has a slot.
    assign occupancy = (CW+1)'(q_count) + (CW+1)'(inflight) - (CW+1)'(pop);
    assign IREQ      = RSTN & ~REDIR_VALID & (occupancy < (CW+1)'(DEPTH));
    assign IADDR     = fpc[PC_W-1:2];

    assign push        = inflight & ~REDIR_VALID;
    assign q_din.instr = INSTR;
    assign q_din.pc    = inflight_pc;

    assign ID_INSTR = q_dout.instr;
    assign ID_PC    = q_dout.pc;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            fpc <= RESET_PC;
        end else if (REDIR_VALID) begin
            fpc <= align_pc(REDIR_PC);
        end else if (IREQ) begin
            fpc <= fpc + 32'd4;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight <= IREQ;
            if (IREQ) begin
                inflight_pc <= fpc;
            end
        end
    end

    risc_toy_ifq #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_ifq (
        .CLK   (CLK),
        .RSTN  (RSTN),
        .push  (push),
        .pop   (pop),
        .flush (REDIR_VALID),
        .din   (q_din),
        .dout  (q_dout),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    no_overflow: assert property (@(posedge CLK) disable iff (!RSTN)
        !(push && q_full && !pop));

endmodule

// File: tb/tb_risc_toy_fetch.sv
// Randomized bench for risc_toy_fetch against a queue-based reference of the
// fetch rules, with directed startup, stall, redirect, wrap and reset cases.
module tb_risc_toy_fetch;
    import risc_toy_pkg::*;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        IREQ;
    logic [29:0] IADDR;
    logic [31:0] INSTR;
    logic        REDIR_VALID;
    logic [31:0] REDIR_PC;
    logic        ID_VALID;
    logic        ID_READY;
    logic [31:0] ID_INSTR;
    logic [31:0] ID_PC;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] mdl_q[$];
    bit          mdl_pend;
    logic [31:0] mdl_pend_pc;
    logic [31:0] mdl_fpc;
    bit          cap_req;
    logic [29:0] cap_addr;

    risc_toy_fetch #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .CLK         (CLK),
        .RSTN        (RSTN),
        .IREQ        (IREQ),
        .IADDR       (IADDR),
        .INSTR       (INSTR),
        .REDIR_VALID (REDIR_VALID),
        .REDIR_PC    (REDIR_PC),
        .ID_VALID    (ID_VALID),
        .ID_READY    (ID_READY),
        .ID_INSTR    (ID_INSTR),
        .ID_PC       (ID_PC)
    );

    always #5 CLK = ~CLK;

    // Instruction memory contents: a fixed, address-unique pattern.
    function automatic logic [31:0] imem(input logic [29:0] a);
        return {a[13:0], 2'b11, ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        mdl_q.delete();
        mdl_pend    = 1'b0;
        mdl_pend_pc = '0;
        mdl_fpc     = RESET_PC;
        cap_req     = 1'b0;
    endtask

    // One clock cycle: drive inputs just after the edge, check at the
    // falling edge, then advance the reference to the next edge.
    task automatic applyStimulus(input bit ready, input bit redir, input logic [31:0] target);
        bit          exp_valid;
        bit          exp_pop;
        bit          exp_req;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        int          occ;
        INSTR       = cap_req ? imem(cap_addr) : $urandom;
        ID_READY    = ready;
        REDIR_VALID = redir;
        REDIR_PC    = target;
        @(negedge CLK);
        exp_valid = (mdl_q.size() != 0) && !redir;
        exp_pc    = (mdl_q.size() != 0) ? mdl_q[0] : 32'h0;
        exp_instr = (mdl_q.size() != 0) ? imem(exp_pc[31:2]) : 32'h0;
        exp_pop   = exp_valid && ready;
        occ       = mdl_q.size() + int'(mdl_pend) - int'(exp_pop);
        exp_req   = !redir && (occ < DEPTH);
        checkOutput("IREQ",     32'(IREQ),     32'(exp_req));
        checkOutput("IADDR",    32'(IADDR),    32'(mdl_fpc[31:2]));
        checkOutput("ID_VALID", 32'(ID_VALID), 32'(exp_valid));
        checkOutput("ID_PC",    ID_PC,         exp_pc);
        checkOutput("ID_INSTR", ID_INSTR,      exp_instr);
        cap_req  = IREQ;
        cap_addr = IADDR;
        if (redir) begin
            mdl_q.delete();
            mdl_pend = 1'b0;
            mdl_fpc  = target & 32'hFFFF_FFFC;
        end else begin
            if (exp_pop) void'(mdl_q.pop_front());
            if (mdl_pend) mdl_q.push_back(mdl_pend_pc);
            mdl_pend    = exp_req;
            mdl_pend_pc = mdl_fpc;
            if (exp_req) mdl_fpc = mdl_fpc + 32'd4;
        end
        @(posedge CLK);
        #1;
    endtask

    // Short asynchronous reset pulse landing between clock edges.
    task automatic pulseReset();
        RSTN = 1'b0;
        #1;
        checkOutput("rst_IREQ",     32'(IREQ),     32'h0);
        checkOutput("rst_ID_VALID", 32'(ID_VALID), 32'h0);
        checkOutput("rst_ID_INSTR", ID_INSTR,      32'h0);
        checkOutput("rst_ID_PC",    ID_PC,         32'h0);
        checkOutput("rst_IADDR",    32'(IADDR),    32'(RESET_PC[31:2]));
        #1;
        RSTN = 1'b1;
        modelReset();
    endtask

    initial begin
        RSTN        = 1'b0;
        ID_READY    = 1'b0;
        REDIR_VALID = 1'b0;
        REDIR_PC    = '0;
        INSTR       = '0;
        modelReset();
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("reset_IREQ",     32'(IREQ),     32'h0);
        checkOutput("reset_ID_VALID", 32'(ID_VALID), 32'h0);
        checkOutput("reset_ID_INSTR", ID_INSTR,      32'h0);
        checkOutput("reset_ID_PC",    ID_PC,         32'h0);
        RSTN = 1'b1;

        // Startup with decode always ready
        repeat (8) applyStimulus(1'b1, 1'b0, '0);

        // Stall from reset, then drain
        pulseReset();
        repeat (5) applyStimulus(1'b0, 1'b0, '0);
        repeat (5) applyStimulus(1'b1, 1'b0, '0);

        // Redirect while the queue holds work
        repeat (2) applyStimulus(1'b1, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b1, 32'h0000_0100);
        repeat (6) applyStimulus(1'b1, 1'b0, '0);

        // Unaligned redirect target
        applyStimulus(1'b1, 1'b1, 32'h0000_0203);
        checkOutput("redir_203_IADDR", 32'(IADDR), 32'h0000_0080);
        repeat (5) applyStimulus(1'b1, 1'b0, '0);

        // PC wrap past the top of the address space
        applyStimulus(1'b1, 1'b1, 32'hFFFF_FFF8);
        repeat (6) applyStimulus(1'b1, 1'b0, '0);

        // Back-to-back redirects, last one wins
        applyStimulus(1'b1, 1'b1, 32'h0000_0040);
        applyStimulus(1'b1, 1'b1, 32'h0000_0080);
        repeat (5) applyStimulus(1'b1, 1'b0, '0);

        // Mid-stream reset pulse
        pulseReset();
        repeat (6) applyStimulus(1'b1, 1'b0, '0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit          rdy;
            bit          rdr;
            logic [31:0] tgt;
            rdy = ($urandom_range(0, 9) < 7);
            rdr = ($urandom_range(0, 24) == 0);
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : $urandom;
            if ($urandom_range(0, 599) == 0) pulseReset();
            applyStimulus(rdy, rdr, tgt);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
